hps_fpga_audio_edge_pio: RTL
============================

HPS_FPGA_AUDIO_EDGE_PIO -- requirements
Module: hps_fpga_audio_edge_pio

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of in_port and of all per-bit registers (1..32).
REQ-002 Parameter: EDGE_TYPE, default 0, captured edge: 0 rising, 1 falling, 2 any.
REQ-003 Parameter: CNT_WIDTH, default 16, width of the edge-event counter (1..32).
REQ-004 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: address  input  2  Avalon-MM word address.
REQ-007 Port: chipselect  input  1  slave select; qualifies writes.
REQ-008 Port: write_n  input  1  active-low write strobe.
REQ-009 Port: writedata  input  32  write data.
REQ-010 Port: in_port  input  DATA_WIDTH  external audio status/sample bits.
REQ-011 Port: readdata  output  32  registered read data, zero-extended above DATA_WIDTH.
REQ-012 Port: irq  output  1  level interrupt request.

Function
REQ-013 Register map: 0 data (RO), 1 irqmask (RW), 2 edgecapture (RW1C), 3 event count (RO, any write clears).
REQ-014 data_s: in_port after the input stage (REQ-031/032); data_d: data_s registered once per clock.
REQ-015 Per-bit edge: rising = data_s & ~data_d; falling = ~data_s & data_d; any = data_s ^ data_d; selected by EDGE_TYPE.
REQ-016 edgecapture bit sets on a detected edge and holds until cleared by a write of 1 to that bit at address 2.
REQ-017 Same-cycle W1C clear and new edge on a bit: bit ends set (edge wins).
REQ-018 Write to address 1 (chipselect=1, write_n=0) loads irqmask <= writedata[DATA_WIDTH-1:0] next cycle.
REQ-019 irq = OR of (edgecapture & irqmask), combinational from registers; no extra latency.
REQ-020 Event counter increments by 1 in each cycle with at least one detected edge on any bit (per cycle, not per bit).
REQ-021 Event counter saturates at 2^CNT_WIDTH-1; no wrap.
REQ-022 Write to address 3 clears the counter; same-cycle clear and edge leaves counter = 1.
REQ-023 Writes to address 0 have no effect; writes with chipselect=0 are ignored.
REQ-024 readdata <= register selected by address every clock, independent of chipselect; read latency 1 cycle.
REQ-025 Bits of readdata above DATA_WIDTH (or CNT_WIDTH for address 3) read 0.
REQ-026 Read of edgecapture does not clear it.

Reset
REQ-027 While reset=1: readdata, irqmask, edgecapture, event counter <= 0; irq = 0 next cycle.
REQ-028 While reset=1: data_d and any synchronizer stages load in_port directly, so no edge is detected on the first cycle after reset.
REQ-029 Reset asserted mid-operation overrides any same-cycle write or edge.
REQ-030 No state other than REQ-027/028 exists; behaviour after reset is fully deterministic.

Configuration
REQ-031 With HPS_FPGA_AUDIO_SYNC_EN defined: in_port passes through a two-flop synchronizer; data_s = second stage; edge-to-edgecapture latency 3 cycles.
REQ-032 Without HPS_FPGA_AUDIO_SYNC_EN: data_s = in_port combinationally; edge-to-edgecapture latency 1 cycle (bit visible the cycle after in_port changes).
REQ-033 Register map, reset values and read latency are identical in both builds.

Verification (DATA_WIDTH=32, EDGE_TYPE=0, CNT_WIDTH=16, macro undefined unless stated)
REQ-034 Reset with in_port=0xFFFF_FFFF, release, hold -> edgecapture=0, count=0, irq=0 for 10 cycles.
REQ-035 irqmask=0x0000_0001; in_port 0x0->0x0000_0003 -> edgecapture=0x3 one cycle later, irq=1, count=1; readdata at address 2 shows 0x3 one further cycle later.
REQ-036 W1C 0x1 to address 2 in the same cycle as a new rising edge on bit 0 -> edgecapture bit 0 stays 1, irq stays 1.
REQ-037 Toggle in_port bit 5 0->1->0 repeatedly 70000 times -> count saturates at 0xFFFF; write address 3 -> count 0.
REQ-038 EDGE_TYPE=2, in_port 0x0->0x8000_0000->0x0 -> edgecapture bit 31 set, count=2.
REQ-039 HPS_FPGA_AUDIO_SYNC_EN defined: in_port bit 0 rises at cycle N -> edgecapture bit 0 set at cycle N+3, not earlier.

Source files
------------

// File: rtl/hps_fpga_audio_edge_pio.sv
// hps_fpga_audio_edge_pio: Avalon-MM edge-capture PIO for audio status bits.
// Captures per-bit edges of in_port into a sticky edgecapture register
// (cleared by writing 1s), raises a level irq for masked bits, and counts
// the cycles that saw at least one edge in a saturating counter.
// Build option: define HPS_FPGA_AUDIO_SYNC_EN to pass in_port through a
// two-flop synchronizer before edge detection (adds two cycles of latency).
module hps_fpga_audio_edge_pio #(
   parameter int DATA_WIDTH = 32,
   parameter int EDGE_TYPE  = 0,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [31:0]           readdata,
   output logic                  irq
);

   logic [DATA_WIDTH-1:0] data_s;
   logic [DATA_WIDTH-1:0] data_d;
   logic [DATA_WIDTH-1:0] edge_det;
   logic [DATA_WIDTH-1:0] irqmask;
   logic [DATA_WIDTH-1:0] edgecapture;
   logic [DATA_WIDTH-1:0] wdata;
   logic [CNT_WIDTH-1:0]  evt_cnt;
   logic [31:0]           rd_next;
   logic                  wr_en;
   logic                  any_edge;
   logic                  unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign wdata        = writedata[DATA_WIDTH-1:0];
   assign unused_wdata = &{1'b0, writedata};

`ifdef HPS_FPGA_AUDIO_SYNC_EN
   logic [DATA_WIDTH-1:0] sync1;
   logic [DATA_WIDTH-1:0] sync2;

   // Two-flop synchronizer; preloaded with in_port in reset so no false edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= in_port;
         sync2 <= in_port;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   assign data_s = sync2;
`else
   assign data_s = in_port;
`endif

   // Delayed copy for edge detection; loads in_port in reset to suppress a
   // spurious edge on the first cycle out of reset.
   always_ff @(posedge clk) begin
      if (reset) data_d <= in_port;
      else       data_d <= data_s;
   end

   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign edge_det = data_s & ~data_d;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign edge_det = ~data_s & data_d;
      end else begin : g_any
         assign edge_det = data_s ^ data_d;
      end
   endgenerate

   assign any_edge = |edge_det;

   // Interrupt mask register.
   always_ff @(posedge clk) begin
      if (reset)                             irqmask <= '0;
      else if (wr_en && address == 2'd1)     irqmask <= wdata;
   end

   // Sticky edge capture; a new edge beats a same-cycle write-1-to-clear.
   always_ff @(posedge clk) begin
      if (reset)                             edgecapture <= '0;
      else if (wr_en && address == 2'd2)     edgecapture <= (edgecapture & ~wdata) | edge_det;
      else                                   edgecapture <= edgecapture | edge_det;
   end

   // Saturating per-cycle edge event counter; any write to address 3 clears.
   always_ff @(posedge clk) begin
      if (reset)
         evt_cnt <= '0;
      else if (wr_en && address == 2'd3)
         evt_cnt <= any_edge ? CNT_WIDTH'(1) : '0;
      else if (any_edge && evt_cnt != {CNT_WIDTH{1'b1}})
         evt_cnt <= evt_cnt + CNT_WIDTH'(1);
   end

   // Read mux, zero-extended to the 32-bit bus.
   always_comb begin
      rd_next = '0;
      case (address)
         2'd0:    rd_next[DATA_WIDTH-1:0] = data_s;
         2'd1:    rd_next[DATA_WIDTH-1:0] = irqmask;
         2'd2:    rd_next[DATA_WIDTH-1:0] = edgecapture;
         default: rd_next[CNT_WIDTH-1:0]  = evt_cnt;
      endcase
   end

   // Registered read data, one cycle latency, independent of chipselect.
   always_ff @(posedge clk) begin
      if (reset) readdata <= '0;
      else       readdata <= rd_next;
   end

   assign irq = |(edgecapture & irqmask);

endmodule
